// File: rtl/frame_stream_gen.sv
// Synthetic camera-style frame source: VSYNC, HREF and RGB444 pixels with a
// ground-truth orange flag and a per-frame orange pixel count.
//
// state | meaning
// IDLE  | waiting for start
// VS    | VSYNC high for VSYNC_LEN cycles, pattern/box latched on entry
// VB    | vertical blank, V_BLANK cycles
// LINE  | HREF high, x counts 0..H_ACTIVE-1
// HB    | horizontal blank, H_BLANK cycles, then next line or frame end
module frame_stream_gen #(
  parameter int H_ACTIVE  = 320,
  parameter int V_ACTIVE  = 240,
  parameter int H_BLANK   = 16,
  parameter int VSYNC_LEN = 8,
  parameter int V_BLANK   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        continuous,
  input  logic [1:0]  pattern,
  input  logic [8:0]  box_x0,
  input  logic [8:0]  box_x1,
  input  logic [7:0]  box_y0,
  input  logic [7:0]  box_y1,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        HREF,
  output logic        VSYNC,
  output logic        is_orange,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic        busy,
  output logic        frame_done,
  output logic [17:0] orange_total
);

  typedef enum logic [2:0] {IDLE, VS, VB, LINE, HB} state_t;

  localparam logic [8:0]  X_LAST  = 9'(H_ACTIVE - 1);
  localparam logic [7:0]  Y_LAST  = 8'(V_ACTIVE - 1);
  localparam logic [15:0] VS_LOAD = 16'(VSYNC_LEN - 1);
  localparam logic [15:0] VB_LOAD = 16'(V_BLANK - 1);
  localparam logic [15:0] HB_LOAD = 16'(H_BLANK - 1);
  // Band edges used by the downstream classifier.
  localparam logic [8:0]  STRIPE_L = 9'd100;
  localparam logic [8:0]  STRIPE_R = 9'd295;

  state_t      state, state_n;
  logic [15:0] tmr, tmr_n;
  logic [8:0]  x_n;
  logic [7:0]  y_n;
  logic        enter_vs;
  logic        orange_n;
  logic        in_box;
  logic [1:0]  pat_q;
  logic [8:0]  bx0_q, bx1_q;
  logic [7:0]  by0_q, by1_q;
  logic [17:0] orange_cnt;

  assign HREF     = (state == LINE);
  assign VSYNC    = (state == VS);
  assign busy     = (state != IDLE);
  assign enter_vs = (state_n == VS) && (state != VS);

  // Next-state, timer and pixel-position logic; frame_done marks the last HB cycle.
  always_comb begin
    state_n    = state;
    tmr_n      = tmr;
    x_n        = x;
    y_n        = y;
    frame_done = 1'b0;
    if (tmr != 16'd0) tmr_n = tmr - 16'd1;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = VS;
          tmr_n   = VS_LOAD;
        end
      end
      VS: begin
        if (tmr == 16'd0) begin
          state_n = VB;
          tmr_n   = VB_LOAD;
        end
      end
      VB: begin
        if (tmr == 16'd0) begin
          state_n = LINE;
          x_n     = 9'd0;
          y_n     = 8'd0;
        end
      end
      LINE: begin
        if (x == X_LAST) begin
          state_n = HB;
          tmr_n   = HB_LOAD;
          x_n     = 9'd0;
        end else begin
          x_n = x + 9'd1;
        end
      end
      HB: begin
        if (tmr == 16'd0) begin
          if (y == Y_LAST) begin
            frame_done = 1'b1;
            y_n        = 8'd0;
            if (continuous) begin
              state_n = VS;
              tmr_n   = VS_LOAD;
            end else begin
              state_n = IDLE;
            end
          end else begin
            state_n = LINE;
            y_n     = y + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Orange decision for the pixel that will be presented next cycle.
  always_comb begin
    in_box   = (x_n >= bx0_q) && (x_n <= bx1_q) && (y_n >= by0_q) && (y_n <= by1_q);
    orange_n = 1'b0;
    case (pat_q)
      2'd0:    orange_n = 1'b1;
      2'd1:    orange_n = in_box;
      2'd2:    orange_n = 1'b0;
      default: orange_n = (x_n < STRIPE_L) || (x_n >= STRIPE_R);
    endcase
  end

  // State, timer and position registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= 16'd0;
      x     <= 9'd0;
      y     <= 8'd0;
    end else begin
      state <= state_n;
      tmr   <= tmr_n;
      x     <= x_n;
      y     <= y_n;
    end
  end

  // Frame configuration is frozen at VS entry so mid-frame edits cannot tear the image.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q <= 2'd0;
      bx0_q <= 9'd0;
      bx1_q <= 9'd0;
      by0_q <= 8'd0;
      by1_q <= 8'd0;
    end else if (enter_vs) begin
      pat_q <= pattern;
      bx0_q <= box_x0;
      bx1_q <= box_x1;
      by0_q <= box_y0;
      by1_q <= box_y1;
    end
  end

  // Registered pixel; non-orange active pixels use a dark grey black level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      red       <= 4'h0;
      green     <= 4'h0;
      blue      <= 4'h0;
      is_orange <= 1'b0;
    end else if (state_n == LINE) begin
      is_orange <= orange_n;
      red       <= orange_n ? 4'hF : 4'h2;
      green     <= orange_n ? 4'h8 : 4'h2;
      blue      <= orange_n ? 4'h0 : 4'h2;
    end else begin
      red       <= 4'h0;
      green     <= 4'h0;
      blue      <= 4'h0;
      is_orange <= 1'b0;
    end
  end

  // Saturating orange counter, cleared at VS entry and published at frame end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      orange_cnt   <= 18'd0;
      orange_total <= 18'd0;
    end else begin
      if (enter_vs) orange_cnt <= 18'd0;
      else if (is_orange && (orange_cnt != 18'h3FFFF)) orange_cnt <= orange_cnt + 18'd1;
      if (frame_done) orange_total <= orange_cnt;
    end
  end

endmodule

// File: tb/tb_frame_stream_gen.sv
// Directed bench for frame_stream_gen. Frame height is reduced to 20 lines so
// several full frames fit in a short run; line width keeps the default 320 so
// the stripe band edges at 100/295 are exercised.
module tb_frame_stream_gen;

  localparam int HA = 320;
  localparam int VA = 20;
  localparam int HB = 16;
  localparam int VSL = 8;
  localparam int VBL = 32;
  localparam int BUDGET = 10000;

  logic        clk = 1'b0;
  logic        rst_n, start, continuous;
  logic [1:0]  pattern;
  logic [8:0]  box_x0, box_x1;
  logic [7:0]  box_y0, box_y1;
  logic [3:0]  red, green, blue;
  logic        HREF, VSYNC, is_orange, busy, frame_done;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [17:0] orange_total;

  int n_chk = 0;
  int n_fail = 0;

  // per-frame observations
  int pulses, bad_len, bad_gap, vs_cyc, vb_cyc, pix_err, seen, done_cnt;
  logic row0 [0:HA-1];

  frame_stream_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
                     .VSYNC_LEN(VSL), .V_BLANK(VBL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .pattern(pattern), .box_x0(box_x0), .box_x1(box_x1),
    .box_y0(box_y0), .box_y1(box_y1),
    .red(red), .green(green), .blue(blue), .HREF(HREF), .VSYNC(VSYNC),
    .is_orange(is_orange), .x(x), .y(y), .busy(busy),
    .frame_done(frame_done), .orange_total(orange_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic model_orange(input logic [1:0] p, input int bx0, input int bx1,
                                        input int by0, input int by1, input int xx, input int yy);
    case (p)
      2'd0: return 1'b1;
      2'd1: return (xx >= bx0) && (xx <= bx1) && (yy >= by0) && (yy <= by1);
      2'd2: return 1'b0;
      default: return (xx < 100) || (xx >= 295);
    endcase
  endfunction

  // Runs one frame from the current negedge until frame_done, then steps one
  // more negedge. Inputs are scrambled after the frame starts and restored
  // partway through, so the output must follow the values latched at VS entry.
  task automatic run_frame(input logic [1:0] p, input int bx0, input int bx1,
                           input int by0, input int by1, input bit do_start,
                           input bit cont_mid);
    int hlen, gap, cyc;
    bit prev_href, done, exp_o;
    pattern = p; box_x0 = 9'(bx0); box_x1 = 9'(bx1); box_y0 = 8'(by0); box_y1 = 8'(by1);
    if (do_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    pattern = ~p; box_x0 = ~box_x0; box_x1 = ~box_x1; box_y0 = ~box_y0; box_y1 = ~box_y1;
    continuous = cont_mid;
    pulses = 0; bad_len = 0; bad_gap = 0; vs_cyc = 0; vb_cyc = 0;
    pix_err = 0; seen = 0; done_cnt = 0;
    hlen = 0; gap = 0; cyc = 0; prev_href = 1'b0; done = 1'b0;
    while (!done && cyc < BUDGET) begin
      if (VSYNC) vs_cyc++;
      if (busy && !VSYNC && !HREF && pulses == 0) vb_cyc++;
      if (HREF) begin
        if (!prev_href) begin
          pulses++;
          if (pulses > 1 && gap != HB) bad_gap++;
          if (pulses == 2) begin
            pattern = p; box_x0 = 9'(bx0); box_x1 = 9'(bx1); box_y0 = 8'(by0); box_y1 = 8'(by1);
          end
        end
        hlen++;
        exp_o = model_orange(p, bx0, bx1, by0, by1, hlen - 1, pulses - 1);
        if (int'(x) != hlen - 1 || int'(y) != pulses - 1) pix_err++;
        if (is_orange !== exp_o) pix_err++;
        if (exp_o && {red, green, blue} !== 12'hF80) pix_err++;
        if (!exp_o && {red, green, blue} !== 12'h222) pix_err++;
        if (is_orange) seen++;
        if (pulses == 1 && hlen <= HA) row0[hlen-1] = is_orange;
      end else begin
        if (prev_href) begin
          if (hlen != HA) bad_len++;
          hlen = 0;
          gap = 0;
        end
        gap++;
        if ({red, green, blue} !== 12'h000 || is_orange !== 1'b0) pix_err++;
      end
      if (frame_done) begin
        done_cnt++;
        done = 1'b1;
      end
      prev_href = HREF;
      @(negedge clk);
      cyc++;
    end
    chk("frame_timeout", done, 1'b1);
    chk("done_width", frame_done, 1'b0);
    chk("after_vsync", VSYNC, cont_mid);
    chk("after_busy", busy, cont_mid);
  endtask

  initial begin
    int found, idle_busy, stray_done;
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; pattern = 2'd0;
    box_x0 = '0; box_x1 = '0; box_y0 = '0; box_y1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sync", {HREF, VSYNC, is_orange, frame_done}, 4'b0000);
    chk("rst_pos", {x, y}, 17'd0);
    chk("rst_rgb", {red, green, blue}, 12'h000);
    chk("rst_total", orange_total, 18'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_start", busy, 1'b0);

    // solid orange
    run_frame(2'd0, 0, 0, 0, 0, 1'b1, 1'b0);
    chk("p0_pulses", pulses, VA);
    chk("p0_len", bad_len, 0);
    chk("p0_gap", bad_gap, 0);
    chk("p0_vsync_len", vs_cyc, VSL);
    chk("p0_vblank_len", vb_cyc, VBL);
    chk("p0_pix", pix_err, 0);
    chk("p0_done_once", done_cnt, 1);
    chk("p0_total", orange_total, 32'd6400);

    // box 10..19 x 5..14
    run_frame(2'd1, 10, 19, 5, 14, 1'b1, 1'b0);
    chk("box_pix", pix_err, 0);
    chk("box_seen", seen, 100);
    chk("box_total", orange_total, 32'd100);

    // reversed x bounds
    run_frame(2'd1, 50, 40, 0, 19, 1'b1, 1'b0);
    chk("rev_pix", pix_err, 0);
    chk("rev_total", orange_total, 32'd0);

    // all dark
    run_frame(2'd2, 0, 0, 0, 0, 1'b1, 1'b0);
    chk("dark_pix", pix_err, 0);
    chk("dark_total", orange_total, 32'd0);

    // stripes, continuous: frame 1 then auto-restarted frame 2
    continuous = 1'b1;
    run_frame(2'd3, 0, 0, 0, 0, 1'b1, 1'b1);
    chk("str_pix", pix_err, 0);
    chk("str_total", orange_total, 32'd2500);
    chk("str_x99", row0[99], 1'b1);
    chk("str_x100", row0[100], 1'b0);
    chk("str_x294", row0[294], 1'b0);
    chk("str_x295", row0[295], 1'b1);
    run_frame(2'd3, 0, 0, 0, 0, 1'b0, 1'b0);
    chk("cont_pulses", pulses, VA);
    chk("cont_pix", pix_err, 0);
    chk("cont_total", orange_total, 32'd2500);

    // reset mid-frame at line 10
    continuous = 1'b1;
    pattern = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    stray_done = 0;
    for (int i = 0; i < BUDGET && found == 0; i++) begin
      if (frame_done) stray_done++;
      if (HREF && y == 8'd10) found = 1;
      else @(negedge clk);
    end
    chk("rst_reach", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_sync", {HREF, VSYNC, is_orange, frame_done}, 4'b0000);
    chk("mid_rst_pos", {x, y}, 17'd0);
    chk("mid_rst_rgb", {red, green, blue}, 12'h000);
    chk("mid_rst_total", orange_total, 18'd0);
    rst_n = 1'b1;
    idle_busy = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) idle_busy++;
      if (frame_done) stray_done++;
    end
    chk("post_rst_idle", idle_busy, 0);
    chk("post_rst_no_done", stray_done, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_vsync", {busy, VSYNC}, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_stream_gen.md
FRAME_STREAM_GEN -- requirements
Module: frame_stream_gen

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 320, meaning active pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 240, meaning active lines per frame.
REQ-003 The block SHALL have parameter H_BLANK, default 16, meaning HREF-low cycles after each active line.
REQ-004 The block SHALL have parameter VSYNC_LEN, default 8, meaning VSYNC-high cycles per frame.
REQ-005 The block SHALL have parameter V_BLANK, default 32, meaning cycles between VSYNC fall and the first line.
REQ-006 The block SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1, meaning a synchronous, active-low reset.
REQ-008 The block SHALL have port start, input, 1, meaning a frame request, sampled only in IDLE.
REQ-009 The block SHALL have port continuous, input, 1, meaning auto-restart after each frame while high.
REQ-010 The block SHALL have port pattern, input, 2, meaning the pattern select: 0 solid orange, 1 box, 2 all black, 3 stripes.
REQ-011 The block SHALL have ports box_x0/box_x1, input, 9 each, meaning the inclusive box column bounds.
REQ-012 The block SHALL have ports box_y0/box_y1, input, 8 each, meaning the inclusive box row bounds.
REQ-013 The block SHALL have ports red/green/blue, output, 4 each, meaning the RGB444 pixel.
REQ-014 The block SHALL have ports HREF and VSYNC, output, 1 each, meaning the line-valid and frame-sync strobes.
REQ-015 The block SHALL have port is_orange, output, 1, meaning the ground-truth orange flag for the current pixel.
REQ-016 The block SHALL have ports x/y, output, 9/8, meaning the current pixel column and row.
REQ-017 The block SHALL have ports busy, frame_done and orange_total, output, 1/1/18, meaning frame in progress, a one-cycle end-of-frame pulse, and the orange pixel count of the last frame.

Function
REQ-018 The block SHALL implement the states IDLE, VS, VB, LINE and HB.
REQ-019 In IDLE, start=1 SHALL move the FSM to VS on the next cycle; busy SHALL be high in all states except IDLE.
REQ-020 On entry to VS, the block SHALL latch pattern and all box_* inputs; input changes mid-frame SHALL have no effect.
REQ-021 VS SHALL hold VSYNC=1 for exactly VSYNC_LEN cycles, then go to VB.
REQ-022 VB SHALL last V_BLANK cycles, then go to LINE with y=0.
REQ-023 LINE SHALL hold HREF=1 for exactly H_ACTIVE consecutive cycles with x counting 0..H_ACTIVE-1, then go to HB.
REQ-024 HB SHALL last H_BLANK cycles; the block SHALL then go to LINE with y+1, or, if y=V_ACTIVE-1, end the frame.
REQ-025 At frame end, the block SHALL pulse frame_done for one cycle and update orange_total, in the same cycle that the FSM leaves HB.
REQ-026 At frame end, the next state SHALL be VS if continuous=1 and IDLE otherwise; start SHALL be ignored outside IDLE.
REQ-027 red/green/blue/is_orange SHALL be registered and aligned with HREF, x and y in the same cycle.
REQ-028 Outside LINE, the pixel outputs SHALL be 0 and is_orange SHALL be 0.
REQ-029 An orange pixel SHALL be R=4'hF, G=4'h8, B=4'h0 with is_orange=1.
REQ-030 A non-orange active pixel SHALL be R=G=B=4'h2 with is_orange=0.
REQ-031 Box pattern: a pixel SHALL be orange iff box_x0<=x<=box_x1 and box_y0<=y<=box_y1; x0>x1 or y0>y1 SHALL produce no orange pixels.
REQ-032 Stripes pattern: a pixel SHALL be orange iff x<100 or x>=295, matching the classifier left/right band edges.
REQ-033 An internal 18-bit counter SHALL count is_orange pixels and clear on VS entry; it SHALL saturate at 18'h3FFFF.

Reset
REQ-034 While rst_n=0 at a clock edge, the block SHALL enter IDLE and clear x, y, HREF, VSYNC, RGB, is_orange, busy, frame_done, orange_total and the internal counter.
REQ-035 Reset asserted mid-frame SHALL abort the frame without a frame_done pulse; after release, the block SHALL stay in IDLE until start, even if continuous=1.

Verification
REQ-036 With pattern=0 and a start pulse, the bench SHALL see 240 HREF pulses of 320 cycles each and 16-cycle gaps, frame_done once, and orange_total=76800.
REQ-037 With pattern=1 and box (10..19, 5..14), the bench SHALL see orange_total=100 and is_orange=1 only at x=10..19, y=5..14.
REQ-038 With pattern=1 and box_x0=50, box_x1=40, the bench SHALL see orange_total=0.
REQ-039 With pattern=3, the bench SHALL see orange_total=240*125=30000, and is_orange SHALL be 1 at x=99 and x=295 and 0 at x=100 and x=294.
REQ-040 With continuous=1, the bench SHALL see the VS entry of the next frame in the cycle after frame_done, and frame 2 SHALL report the same orange_total as frame 1.
REQ-041 With rst_n=0 at y=100, the bench SHALL see all outputs 0 in the next cycle, no frame_done, and the block in IDLE until start.
